// File: rtl/posit_decode_pipe.sv
// rtl/posit_decode_pipe.sv - two-stage pipelined posit field extractor
// S1 holds sign/flags/magnitude; S2 holds the decoded scale and mantissa.
module posit_decode_pipe #(
  parameter int N  = 32,
  parameter int ES = 2,
  parameter int RS = $clog2(N),
  localparam int SW = RS + ES + 2,
  localparam int MW = N - ES - 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_posit,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sign,
  output logic          out_zero,
  output logic          out_nar,
  output logic [SW-1:0] out_scale,
  output logic [MW-1:0] out_mant
);

  logic          s1_valid_q, s1_sign_q, s1_zero_q, s1_nar_q;
  logic [N-2:0]  s1_mag_q;
  logic          s1_sign_d, s1_zero_d, s1_nar_d;
  logic [N-2:0]  s1_mag_d;

  logic          s2_valid_q, s2_sign_q, s2_zero_q, s2_nar_q;
  logic [SW-1:0] s2_scale_q, s2_scale_d;
  logic [MW-1:0] s2_mant_q, s2_mant_d;

  logic s2_free, accept, advance;

  assign s2_free  = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_free;
  assign accept   = in_valid && in_ready;
  assign advance  = s1_valid_q && s2_free;

  // Only the low N-1 bits of the magnitude matter: the MSB is 0 for every
  // word except NaR, which is flagged and never decoded.
  always_comb begin
    s1_sign_d = in_posit[N-1];
    s1_zero_d = (in_posit == '0);
    s1_nar_d  = (in_posit == {1'b1, {(N-1){1'b0}}});
    s1_mag_d  = s1_sign_d ? (~in_posit[N-2:0] + (N-1)'(1)) : in_posit[N-2:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_nar_q   <= 1'b0;
      s1_mag_q   <= '0;
    end else if (accept) begin
      s1_valid_q <= 1'b1;
      s1_sign_q  <= s1_sign_d;
      s1_zero_q  <= s1_zero_d;
      s1_nar_q   <= s1_nar_d;
      s1_mag_q   <= s1_mag_d;
    end else if (advance) begin
      s1_valid_q <= 1'b0;
    end
  end

  logic            reg_bit, run_done;
  logic [RS-1:0]   run_len;
  logic signed [RS:0] run_s, k_val;
  logic [N-4:0]    rest;
  logic [SW-1:0]   e_ext;

  assign reg_bit = s1_mag_q[N-2];

  always_comb begin
    run_len  = '0;
    run_done = 1'b0;
    for (int i = N - 2; i >= 0; i--) begin
      if (!run_done) begin
        if (s1_mag_q[i] == reg_bit) run_len = run_len + RS'(1);
        else run_done = 1'b1;
      end
    end
  end

  // The run is at least one bit, so shifting the tail by run_len-1 lines up the
  // first bit after the terminator at the MSB of rest.
  assign run_s = $signed({1'b0, run_len});
  assign k_val = reg_bit ? (run_s - (RS+1)'(1)) : -run_s;
  assign rest  = s1_mag_q[N-4:0] << (run_len - RS'(1));

  if (ES > 0) begin : g_exp
    assign e_ext = SW'(rest[N-4 -: ES]);
  end else begin : g_noexp
    assign e_ext = '0;
  end

  always_comb begin
    s2_scale_d = '0;
    s2_mant_d  = '0;
    if (!s1_zero_q && !s1_nar_q) begin
      s2_scale_d = (SW'(k_val) <<< ES) + e_ext;
      s2_mant_d  = {1'b1, rest[N-4-ES:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_nar_q   <= 1'b0;
      s2_scale_q <= '0;
      s2_mant_q  <= '0;
    end else if (advance) begin
      s2_valid_q <= 1'b1;
      s2_sign_q  <= s1_sign_q;
      s2_zero_q  <= s1_zero_q;
      s2_nar_q   <= s1_nar_q;
      s2_scale_q <= s2_scale_d;
      s2_mant_q  <= s2_mant_d;
    end else if (out_ready) begin
      s2_valid_q <= 1'b0;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_sign  = s2_sign_q;
  assign out_zero  = s2_zero_q;
  assign out_nar   = s2_nar_q;
  assign out_scale = s2_scale_q;
  assign out_mant  = s2_mant_q;

endmodule

// File: tb/tb_posit_decode_pipe.sv
// tb/tb_posit_decode_pipe.sv - self-checking bench for posit_decode_pipe
module tb_posit_decode_pipe;

  localparam int SWA = 9, MWA = 28, SWB = 7, MWB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 1;
  logic [31:0]     a_in_posit = 0;
  logic            a_out_sign, a_out_zero, a_out_nar;
  logic [SWA-1:0]  a_out_scale;
  logic [MWA-1:0]  a_out_mant;

  logic            b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 1;
  logic [7:0]      b_in_posit = 0;
  logic            b_out_sign, b_out_zero, b_out_nar;
  logic [SWB-1:0]  b_out_scale;
  logic [MWB-1:0]  b_out_mant;

  posit_decode_pipe #(.N(32), .ES(2)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_posit(a_in_posit),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_sign(a_out_sign), .out_zero(a_out_zero), .out_nar(a_out_nar),
    .out_scale(a_out_scale), .out_mant(a_out_mant)
  );

  posit_decode_pipe #(.N(8), .ES(2)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_posit(b_in_posit),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sign(b_out_sign), .out_zero(b_out_zero), .out_nar(b_out_nar),
    .out_scale(b_out_scale), .out_mant(b_out_mant)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic   sign;
    logic   zero;
    logic   nar;
    int     scale;
    longint mant;
  } dec_t;

  // Walks the posit bit by bit: sign, regime run, terminator, ES exponent bits,
  // then fraction bits under a hidden 1; bits past the word end read as 0.
  function automatic dec_t model(input int n, input int es, input longint w);
    dec_t d;
    longint full, v, mag;
    int idx, m, k, e, bitv;
    logic r;
    full = longint'(1) << n;
    v = w & (full - 1);
    d.sign = ((v >> (n - 1)) & 1) != 0;
    d.zero = (v == 0);
    d.nar = (v == full / 2);
    d.scale = 0;
    d.mant = 0;
    if (d.zero || d.nar) return d;
    mag = d.sign ? full - v : v;
    r = ((mag >> (n - 2)) & 1) != 0;
    m = 0;
    idx = n - 2;
    while (idx >= 0 && ((((mag >> idx) & 1) != 0) == r)) begin
      m++;
      idx--;
    end
    idx--;
    k = r ? m - 1 : -m;
    e = 0;
    for (int j = 0; j < es; j++) begin
      bitv = (idx >= 0) ? int'((mag >> idx) & 1) : 0;
      e = e * 2 + bitv;
      idx--;
    end
    d.mant = 1;
    for (int j = 1; j < n - es - 2; j++) begin
      bitv = (idx >= 0) ? int'((mag >> idx) & 1) : 0;
      d.mant = d.mant * 2 + longint'(bitv);
      idx--;
    end
    d.scale = k * (1 << es) + e;
    return d;
  endfunction

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_hs: a_ov=%b a_ir=%b b_ov=%b b_ir=%b, required 0 1 0 1",
               a_out_valid, a_in_ready, b_out_valid, b_in_ready);
    end
    checks++;
    if ({a_out_sign, a_out_zero, a_out_nar, a_out_scale, a_out_mant} !== '0 ||
        {b_out_sign, b_out_zero, b_out_nar, b_out_scale, b_out_mant} !== '0) begin
      errors++;
      $display("FAIL reset_data: a_scale=%0h a_mant=%0h b_scale=%0h b_mant=%0h, required all 0",
               a_out_scale, a_out_mant, b_out_scale, b_out_mant);
    end
    rst = 1'b0;
  endtask

  task automatic test_decode;
    logic [31:0] vw[8] = '{32'h40000000, 32'h44000000, 32'h48000000, 32'hC0000000,
                           32'h7FFFFFFF, 32'h00000001, 32'h00000000, 32'h80000000};
    logic [2:0]  vf[8] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b000, 3'b000, 3'b010, 3'b101};
    int          vs[8] = '{0, 0, 1, 0, 120, -120, 0, 0};
    int          vm[8] = '{32'h8000000, 32'hC000000, 32'h8000000, 32'h8000000,
                           32'h8000000, 32'h8000000, 0, 0};
    logic [31:0] w;
    dec_t d;
    int cyc;
    a_out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      w = (i < 8) ? vw[i] : $urandom;
      if (i < 8) begin
        d.sign = vf[i][2]; d.zero = vf[i][1]; d.nar = vf[i][0];
        d.scale = vs[i]; d.mant = longint'(vm[i]);
      end else begin
        d = model(32, 2, longint'(w));
      end
      @(negedge clk);
      a_in_valid = 1'b1;
      a_in_posit = w;
      @(posedge clk);
      @(negedge clk);
      a_in_valid = 1'b0;
      a_in_posit = $urandom;
      cyc = 0;
      while (!a_out_valid && cyc < 8) begin
        @(negedge clk);
        cyc++;
      end
      checks++;
      if (!a_out_valid) begin
        errors++;
        $display("FAIL decode_timeout: word %h produced no output", w);
      end else if ({a_out_sign, a_out_zero, a_out_nar} !== {d.sign, d.zero, d.nar} ||
                   $signed(a_out_scale) != d.scale || longint'(a_out_mant) != d.mant) begin
        errors++;
        $display("FAIL decode %h: got s%b z%b n%b scale %0d mant %h, required s%b z%b n%b scale %0d mant %h",
                 w, a_out_sign, a_out_zero, a_out_nar, $signed(a_out_scale), a_out_mant,
                 d.sign, d.zero, d.nar, d.scale, d.mant);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [31:0] w[4];
    dec_t d;
    for (int i = 0; i < 4; i++) w[i] = $urandom;
    a_out_ready = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      checks++;
      if (c >= 2 && c <= 5) begin
        d = model(32, 2, longint'(w[c-2]));
        if (a_out_valid !== 1'b1 || $signed(a_out_scale) != d.scale || longint'(a_out_mant) != d.mant ||
            a_out_sign !== d.sign) begin
          errors++;
          $display("FAIL b2b_out%0d: got v%b scale %0d mant %h, required v1 scale %0d mant %h",
                   c - 2, a_out_valid, $signed(a_out_scale), a_out_mant, d.scale, d.mant);
        end
      end else if (a_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b_idle%0d: out_valid %b, required 0", c, a_out_valid);
      end
      if (c < 4) begin
        checks++;
        if (a_in_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_ready%0d: in_ready %b, required 1", c, a_in_ready);
        end
      end
      a_in_valid = (c < 4);
      a_in_posit = (c < 4) ? w[c] : $urandom;
    end
    a_in_valid = 1'b0;
  endtask

  task automatic test_backpressure;
    logic [31:0] w[3];
    dec_t d[3];
    logic exp_ir[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      w[i] = $urandom;
      d[i] = model(32, 2, longint'(w[i]));
    end
    a_out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      a_in_valid = 1'b1;
      a_in_posit = w[(c < 2) ? c : 2];
      #1;
      checks++;
      if (a_in_ready !== exp_ir[c]) begin
        errors++;
        $display("FAIL bp_ready%0d: in_ready %b, required %b", c, a_in_ready, exp_ir[c]);
      end
      if (c >= 2) begin
        checks++;
        if (a_out_valid !== 1'b1 || $signed(a_out_scale) != d[0].scale || longint'(a_out_mant) != d[0].mant) begin
          errors++;
          $display("FAIL bp_hold%0d: got v%b scale %0d mant %h, required v1 scale %0d mant %h",
                   c, a_out_valid, $signed(a_out_scale), a_out_mant, d[0].scale, d[0].mant);
        end
      end
    end
    a_out_ready = 1'b1;
    #1;
    checks++;
    if (a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready: in_ready %b, required 1", a_in_ready);
    end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      a_in_valid = 1'b0;
      checks++;
      if (c < 3) begin
        if (a_out_valid !== 1'b1 || $signed(a_out_scale) != d[c].scale || longint'(a_out_mant) != d[c].mant) begin
          errors++;
          $display("FAIL bp_drain%0d: got v%b scale %0d mant %h, required v1 scale %0d mant %h",
                   c, a_out_valid, $signed(a_out_scale), a_out_mant, d[c].scale, d[c].mant);
        end
      end else if (a_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL bp_empty: out_valid %b, required 0", a_out_valid);
      end
    end
  endtask

  task automatic test_reset_midflight;
    a_out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      a_in_valid = 1'b1;
      a_in_posit = $urandom | 32'h1;
    end
    @(negedge clk);
    a_in_valid = 1'b0;
    #1;
    checks++;
    if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_full: out_valid %b in_ready %b, required 1 0", a_out_valid, a_in_ready);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out_scale !== '0 || a_out_mant !== '0) begin
      errors++;
      $display("FAIL rst_async: out_valid %b in_ready %b scale %h mant %h, required 0 1 0 0",
               a_out_valid, a_in_ready, a_out_scale, a_out_mant);
    end
    @(negedge clk);
    rst = 1'b0;
    a_out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (a_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_stale%0d: out_valid %b, required 0", c, a_out_valid);
      end
    end
  endtask

  task automatic test_sweep8;
    int expq[$];
    int i = 0, got = 0, cyc = 0, w;
    logic acc, pop;
    dec_t d;
    while (got < 256 && cyc < 4000) begin
      @(negedge clk);
      b_out_ready = ($urandom_range(0, 3) != 0);
      b_in_valid = (i < 256) && ($urandom_range(0, 4) != 0);
      b_in_posit = (i < 256) ? 8'(i) : 8'($urandom);
      #1;
      acc = b_in_valid && b_in_ready;
      pop = b_out_valid && b_out_ready;
      if (pop) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL sweep_extra: unexpected output scale %0d mant %h", $signed(b_out_scale), b_out_mant);
        end else begin
          w = expq.pop_front();
          d = model(8, 2, longint'(w));
          if ({b_out_sign, b_out_zero, b_out_nar} !== {d.sign, d.zero, d.nar} ||
              $signed(b_out_scale) != d.scale || longint'(b_out_mant) != d.mant) begin
            errors++;
            $display("FAIL sweep %02h: got s%b z%b n%b scale %0d mant %h, required s%b z%b n%b scale %0d mant %h",
                     w, b_out_sign, b_out_zero, b_out_nar, $signed(b_out_scale), b_out_mant,
                     d.sign, d.zero, d.nar, d.scale, d.mant);
          end
        end
        got++;
      end
      if (acc) begin
        expq.push_back(i);
        i++;
      end
      cyc++;
    end
    @(negedge clk);
    b_in_valid = 1'b0;
    checks++;
    if (got != 256) begin
      errors++;
      $display("FAIL sweep_count: received %0d words, required 256", got);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    test_reset;
    test_decode;
    test_back_to_back;
    test_backpressure;
    test_reset_midflight;
    test_sweep8;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/posit_decode_pipe.md
# posit_decode_pipe

Two-stage pipelined posit field extractor with valid/ready handshakes on both sides. It accepts one N-bit posit word per cycle and emits sign, special-case flags, a combined signed scale (regime·2^ES + exponent) and a left-aligned mantissa with the hidden bit. It sits directly upstream of the Optimised_PM posit multiplier datapath and feeds one operand lane; two instances feed the two operands.

## Interface
- N, default 32: posit word width (N ≥ 8).
- ES, default 2: exponent field width (0..4).
- RS, default $clog2(N): regime count width (derived; do not override).
- SW, derived = RS+ES+2: signed scale width (9 for defaults).
- MW, derived = N-ES-2: mantissa width including hidden bit (28 for defaults).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block accepts input this cycle.
- in_posit  in  N  posit word (two's-complement encoded).
- out_valid  out  1  decoded result present.
- out_ready  in  1  consumer accepts result this cycle.
- out_sign  out  1  sign of the input posit.
- out_zero  out  1  input was 0.
- out_nar  out  1  input was NaR (1 followed by N-1 zeros).
- out_scale  out  SW  signed scale k·2^ES + e.
- out_mant  out  MW  1.f, hidden bit at MSB, fraction left-aligned, zero-padded.

## Operation
- Stage 1 (S1) register: captures sign, zero/NaR flags, and magnitude (two's complement of in_posit when sign=1, else in_posit).
- Stage 2 (S2) register: from S1 magnitude bits [N-2:0]: regime run length m of identical leading bits; regime bit r = bit N-2; k = m-1 if r=1, else -m; skip run plus terminator; next ES bits are e (bits beyond the word end read as 0); remaining bits are the fraction, left-aligned under a hidden 1.
- out_scale = k·2^ES + e, sign-extended to SW; range for defaults −120..+120.
- Maximal regime (run reaches LSB, no terminator): e=0, fraction=0.
- Zero or NaR: out_scale=0, out_mant=0, out_sign = input MSB (0 for zero, 1 for NaR); exactly one of out_zero/out_nar set.
- Flags and data travel together; no reordering, no dropping, no duplication.
- Handshake: transfer on a side occurs when valid && ready in the same cycle.
- s2_free = !S2.valid || out_ready; in_ready = !S1.valid || s2_free (combinational, no dependence on in_valid).
- S1→S2 move when S1.valid && s2_free; S2 cleared when out_ready and nothing moves in.
- out_valid = S2.valid; output fields registered, stable while out_valid && !out_ready.

## Timing
- Reset: S1.valid=S2.valid=0 asynchronously; out_valid=0, in_ready=1, all data outputs 0.
- Latency: word accepted at edge t appears on outputs after edge t+1 (out_valid high in cycle following S1 capture); 2 cycles in→out with no stall.
- Throughput: 1 word/cycle while out_ready=1.
- Full: both stages valid and out_ready=0 → in_ready=0; capacity exactly 2 words.
- Simultaneous: out_ready=1 with both stages full → S2 drains, S1 advances and new input accepted same edge.
- rst mid-operation: in-flight words discarded immediately, no partial output after release.
- in_posit sampled only on an accepted handshake; X on in_posit while !in_valid must not propagate.

## Test plan
- Decode (N=32, ES=2), out_ready=1: 0x40000000 → sign0, scale 0, mant 0x8000000; 0x44000000 → scale 0, mant 0xC000000; 0x48000000 → scale 1, mant 0x8000000; 0xC0000000 → sign1, scale 0, mant 0x8000000.
- Extremes: 0x7FFFFFFF → scale +120, mant 0x8000000; 0x00000001 → scale −120, mant 0x8000000; 0x00000000 → zero=1; 0x80000000 → nar=1, sign=1, scale 0, mant 0.
- Latency/throughput: 4 back-to-back words, out_ready=1 → each result exactly 2 cycles after acceptance, out_valid high 4 consecutive cycles.
- Backpressure: out_ready=0, offer 3 words → 2 accepted, in_ready=0 on third; raise out_ready → outputs in order, third accepted the same edge S2 drains.
- Reset: assert rst for 1 cycle with both stages full → out_valid 0 within the reset cycle, in_ready=1, no stale outputs after release.
- Exhaustive N=8, ES=2 sweep of all 256 words with random out_ready stalls → every field matches a behavioural decode model, order preserved.
